// File: rtl/pwm_multi_axil.sv
// Multi-channel PWM generator with an AXI4-Lite register interface.
// Shadow PERIOD/DUTY registers are copied into the active set atomically at wrap, while disabled, or on FORCE_LOAD.
module pwm_multi_axil #(
    parameter int NUM_CH             = 4,
    parameter int CNT_W              = 16,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] AWADDR,
    input  logic [2:0]                    AWPROT,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [31:0]                   WDATA,
    input  logic [3:0]                    WSTRB,
    input  logic                          WVALID,
    output logic                          WREADY,
    output logic [1:0]                    BRESP,
    output logic                          BVALID,
    input  logic                          BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] ARADDR,
    input  logic [2:0]                    ARPROT,
    input  logic                          ARVALID,
    output logic                          ARREADY,
    output logic [31:0]                   RDATA,
    output logic [1:0]                    RRESP,
    output logic                          RVALID,
    input  logic                          RREADY,
    output logic [NUM_CH-1:0]             pwm_o,
    output logic                          irq
);

    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_PERIOD = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_POL    = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(3);

    logic                          bvalid_reg;
    logic                          rvalid_reg;
    logic [31:0]                   rdata_reg;
    logic                          en_reg;
    logic                          irq_en_reg;
    logic                          force_reg;
    logic                          wrap_reg;
    logic [CNT_W-1:0]              period_shadow_reg;
    logic [CNT_W-1:0]              period_act_reg;
    logic [CNT_W-1:0]              cnt_reg;
    logic [NUM_CH-1:0]             pol_reg;
    logic [NUM_CH-1:0][CNT_W-1:0]  duty_shadow_all;

    logic                          wr_fire;
    logic                          rd_fire;
    logic [IDX_W-1:0]              aw_idx;
    logic [IDX_W-1:0]              ar_idx;
    logic [31:0]                   wmask;
    logic [CNT_W-1:0]              wr_mask;
    logic [CNT_W-1:0]              wr_data;
    logic                          wrap_evt;
    logic                          load;
    logic [31:0]                   rd_word;
    logic                          unused_ok;

    // Ready strobes are gated by ARESETN so nothing handshakes while reset is held.
    assign wr_fire = ARESETN && AWVALID && WVALID && !bvalid_reg;
    assign rd_fire = ARESETN && ARVALID && !rvalid_reg;
    assign AWREADY = wr_fire;
    assign WREADY  = wr_fire;
    assign ARREADY = rd_fire;
    assign BVALID  = bvalid_reg;
    assign BRESP   = 2'b00;
    assign RVALID  = rvalid_reg;
    assign RDATA   = rdata_reg;
    assign RRESP   = 2'b00;
    assign irq     = wrap_reg && irq_en_reg;

    assign aw_idx  = AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_idx  = ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_mask = wmask[CNT_W-1:0];
    assign wr_data = WDATA[CNT_W-1:0];
    assign unused_ok = ^{AWPROT, ARPROT, WDATA, wmask, AWADDR[1:0], ARADDR[1:0]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_strb
            assign wmask[8*gi +: 8] = {8{WSTRB[gi]}};
        end
    endgenerate

    // A counter that overshoots a freshly force-loaded smaller period also wraps.
    assign wrap_evt = en_reg && (cnt_reg >= period_act_reg);
    assign load     = wrap_evt || !en_reg || force_reg;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            bvalid_reg <= 1'b0;
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            if (wr_fire) begin
                bvalid_reg <= 1'b1;
            end else if (BREADY) begin
                bvalid_reg <= 1'b0;
            end
            if (rd_fire) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= rd_word;
            end else if (RREADY) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            en_reg            <= 1'b0;
            irq_en_reg        <= 1'b0;
            force_reg         <= 1'b0;
            wrap_reg          <= 1'b0;
            period_shadow_reg <= '0;
            pol_reg           <= '0;
        end else begin
            force_reg <= wr_fire && (aw_idx == IDX_CTRL) && WSTRB[0] && WDATA[2];
            if (wr_fire && (aw_idx == IDX_CTRL) && WSTRB[0]) begin
                en_reg     <= WDATA[0];
                irq_en_reg <= WDATA[1];
            end
            if (wr_fire && (aw_idx == IDX_PERIOD)) begin
                period_shadow_reg <= (period_shadow_reg & ~wr_mask) | (wr_data & wr_mask);
            end
            if (wr_fire && (aw_idx == IDX_POL)) begin
                pol_reg <= (pol_reg & ~wmask[NUM_CH-1:0]) | (WDATA[NUM_CH-1:0] & wmask[NUM_CH-1:0]);
            end
            // A wrap in the same cycle as a clear keeps the flag set.
            if (wrap_evt) begin
                wrap_reg <= 1'b1;
            end else if (wr_fire && (aw_idx == IDX_STATUS) && WSTRB[0] && WDATA[0]) begin
                wrap_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cnt_reg        <= '0;
            period_act_reg <= '0;
        end else begin
            cnt_reg <= (!en_reg || wrap_evt) ? '0 : cnt_reg + 1'b1;
            if (load) begin
                period_act_reg <= period_shadow_reg;
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam logic [IDX_W-1:0] DUTY_IDX = IDX_W'(4 + gi);
            logic [CNT_W-1:0] duty_shadow_reg;
            logic [CNT_W-1:0] duty_act_reg;
            logic             pwm_reg;

            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) begin
                    duty_shadow_reg <= '0;
                    duty_act_reg    <= '0;
                    pwm_reg         <= 1'b0;
                end else begin
                    if (wr_fire && (aw_idx == DUTY_IDX)) begin
                        duty_shadow_reg <= (duty_shadow_reg & ~wr_mask) | (wr_data & wr_mask);
                    end
                    if (load) begin
                        duty_act_reg <= duty_shadow_reg;
                    end
                    pwm_reg <= en_reg ? ((cnt_reg < duty_act_reg) ^ pol_reg[gi]) : pol_reg[gi];
                end
            end

            assign duty_shadow_all[gi] = duty_shadow_reg;
            assign pwm_o[gi]           = pwm_reg;
        end
    endgenerate

    always_comb begin
        rd_word = '0;
        case (ar_idx)
            IDX_CTRL:   rd_word[1:0]        = {irq_en_reg, en_reg};
            IDX_PERIOD: rd_word[CNT_W-1:0]  = period_shadow_reg;
            IDX_POL:    rd_word[NUM_CH-1:0] = pol_reg;
            IDX_STATUS: rd_word[0]          = wrap_reg;
            default: begin
                for (int n = 0; n < NUM_CH; n++) begin
                    if (ar_idx == IDX_W'(4 + n)) begin
                        rd_word[CNT_W-1:0] = duty_shadow_all[n];
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_multi_axil.sv
// Randomized AXI4-Lite traffic against pwm_multi_axil, checked every cycle against a rule-based reference model.
module tb_pwm_multi_axil;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int AW     = 6;

    logic              ACLK = 1'b0;
    logic              ARESETN = 1'b0;
    logic [AW-1:0]     AWADDR = '0;
    logic [2:0]        AWPROT = '0;
    logic              AWVALID = 1'b0;
    logic              AWREADY;
    logic [31:0]       WDATA = '0;
    logic [3:0]        WSTRB = '0;
    logic              WVALID = 1'b0;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY = 1'b0;
    logic [AW-1:0]     ARADDR = '0;
    logic [2:0]        ARPROT = '0;
    logic              ARVALID = 1'b0;
    logic              ARREADY;
    logic [31:0]       RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY = 1'b0;
    logic [NUM_CH-1:0] pwm_o;
    logic              irq;

    always #5 ACLK = ~ACLK;

    pwm_multi_axil #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .C_S_AXI_ADDR_WIDTH(AW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .pwm_o(pwm_o), .irq(irq)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    bit                m_en, m_irqen, m_force, m_wrap, m_bvalid, m_rvalid;
    bit [CNT_W-1:0]    m_period_sh, m_period_act, m_cnt;
    bit [CNT_W-1:0]    m_duty_sh [NUM_CH];
    bit [CNT_W-1:0]    m_duty_act[NUM_CH];
    bit [NUM_CH-1:0]   m_pol, m_pwm;
    bit [31:0]         m_rdata;
    bit                last_wfire, last_rfire;

    function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] data, input bit [3:0] strb);
        bit [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

    function automatic bit [31:0] m_read(input bit [AW-1:0] a);
        int idx = int'(a) / 4;
        if (idx == 0) return {30'd0, m_irqen, m_en};
        if (idx == 1) return 32'(m_period_sh);
        if (idx == 2) return 32'(m_pol);
        if (idx == 3) return {31'd0, m_wrap};
        if (idx >= 4 && idx < 4 + NUM_CH) return 32'(m_duty_sh[idx-4]);
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_en = 0; m_irqen = 0; m_force = 0; m_wrap = 0; m_bvalid = 0; m_rvalid = 0;
        m_period_sh = 0; m_period_act = 0; m_cnt = 0; m_pol = 0; m_pwm = 0; m_rdata = 0;
        for (int n = 0; n < NUM_CH; n++) begin
            m_duty_sh[n] = 0;
            m_duty_act[n] = 0;
        end
    endtask

    // One clock of DUT and model; inputs must stay constant until the edge.
    task automatic tick();
        bit wfire, rfire, wrapev, load, old_force;
        bit [31:0] nw;
        int widx;
        #1;
        wfire = AWVALID && WVALID && !m_bvalid;
        rfire = ARVALID && !m_rvalid;
        check("awready", AWREADY, wfire);
        check("wready", WREADY, wfire);
        check("arready", ARREADY, rfire);
        @(posedge ACLK);
        last_wfire = wfire;
        last_rfire = rfire;
        wrapev = m_en && (m_cnt >= m_period_act);
        old_force = m_force;
        load = wrapev || !m_en || old_force;
        for (int n = 0; n < NUM_CH; n++)
            m_pwm[n] = m_en ? ((m_cnt < m_duty_act[n]) ^ m_pol[n]) : m_pol[n];
        if (load) begin
            m_period_act = m_period_sh;
            for (int n = 0; n < NUM_CH; n++) m_duty_act[n] = m_duty_sh[n];
        end
        m_cnt = (!m_en || wrapev) ? '0 : m_cnt + 1'b1;
        if (rfire) begin
            m_rdata = m_read(ARADDR);
            m_rvalid = 1;
        end else if (RREADY) m_rvalid = 0;
        m_force = 0;
        if (wfire) begin
            widx = int'(AWADDR) / 4;
            m_bvalid = 1;
            if (widx == 0 && WSTRB[0]) begin
                m_en = WDATA[0]; m_irqen = WDATA[1]; m_force = WDATA[2];
            end else if (widx == 1) begin
                nw = merge(32'(m_period_sh), WDATA, WSTRB); m_period_sh = nw[CNT_W-1:0];
            end else if (widx == 2) begin
                nw = merge(32'(m_pol), WDATA, WSTRB); m_pol = nw[NUM_CH-1:0];
            end else if (widx == 3 && WSTRB[0] && WDATA[0]) begin
                m_wrap = 0;
            end else if (widx >= 4 && widx < 4 + NUM_CH) begin
                nw = merge(32'(m_duty_sh[widx-4]), WDATA, WSTRB); m_duty_sh[widx-4] = nw[CNT_W-1:0];
            end
        end else if (BREADY) m_bvalid = 0;
        if (wrapev) m_wrap = 1;
        #1;
        check("pwm_o", pwm_o, m_pwm);
        check("irq", irq, m_wrap && m_irqen);
        check("bvalid", BVALID, m_bvalid);
        check("rvalid", RVALID, m_rvalid);
        if (m_rvalid) begin
            check("rdata", RDATA, m_rdata);
            check("rresp", RRESP, 0);
        end
        if (m_bvalid) check("bresp", BRESP, 0);
    endtask

    task automatic axi_write(input bit [AW-1:0] addr, input bit [31:0] data, input bit [3:0] strb, input int bdelay);
        int guard = 0;
        AWADDR = addr; WDATA = data; WSTRB = strb; AWVALID = 1; WVALID = 1; BREADY = 0;
        do begin tick(); guard++; end while (!last_wfire && guard < 20);
        check("aw_handshake", last_wfire, 1);
        AWVALID = 0; WVALID = 0;
        repeat (bdelay) tick();
        BREADY = 1;
        guard = 0;
        while (BVALID && guard < 20) begin tick(); guard++; end
        check("b_done", BVALID, 0);
        BREADY = 0;
        $display("WR addr=0x%02h data=0x%08h strb=%b", addr, data, strb);
    endtask

    task automatic axi_read(input bit [AW-1:0] addr, input int rdelay, output bit [31:0] data);
        int guard = 0;
        ARADDR = addr; ARVALID = 1; RREADY = 0;
        do begin tick(); guard++; end while (!last_rfire && guard < 20);
        check("ar_handshake", last_rfire, 1);
        ARVALID = 0;
        data = RDATA;
        repeat (rdelay) tick();
        RREADY = 1;
        guard = 0;
        while (RVALID && guard < 20) begin tick(); guard++; end
        check("r_done", RVALID, 0);
        RREADY = 0;
        $display("RD addr=0x%02h data=0x%08h", addr, data);
    endtask

    task automatic count_high(input int ch, input int cycles, output int hits);
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (pwm_o[ch]) hits++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pwm"}, pwm_o, 0);
        check({tag, "_irq"}, irq, 0);
        check({tag, "_bvalid"}, BVALID, 0);
        check({tag, "_rvalid"}, RVALID, 0);
        check({tag, "_awready"}, AWREADY, 0);
        check({tag, "_wready"}, WREADY, 0);
        check({tag, "_arready"}, ARREADY, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [31:0] rd;
        int hits;
        bit [AW-1:0] addr_tbl[10] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18, 6'h1C, 6'h20, 6'h3C};

        // Reset state
        model_reset();
        #2;
        check_reset_outputs("por");
        repeat (3) @(negedge ACLK);
        ARESETN = 1;
        tick();

        // Basic PWM: period 10, duty 3
        axi_write(6'h04, 9, 4'hF, 0);
        axi_write(6'h10, 3, 4'hF, 0);
        axi_write(6'h00, 1, 4'hF, 0);
        axi_read(6'h04, 0, rd); check("rd_period", rd, 9);
        axi_read(6'h10, 1, rd); check("rd_duty0", rd, 3);
        count_high(0, 20, hits); check("duty3_hits", hits, 6);

        // Shadow change waits for the wrap; FORCE_LOAD applies immediately
        axi_write(6'h10, 7, 4'hF, 0);
        repeat (10) tick();
        count_high(0, 20, hits); check("duty7_hits", hits, 14);
        axi_write(6'h10, 2, 4'hF, 0);
        axi_write(6'h00, 5, 4'hF, 0);
        count_high(0, 20, hits); check("force_duty2_hits", hits, 4);

        // Duty boundaries with polarity
        axi_write(6'h10, 0, 4'hF, 0);
        axi_write(6'h14, 10, 4'hF, 0);
        axi_write(6'h08, 1, 4'hF, 0);
        axi_write(6'h00, 5, 4'hF, 0);
        count_high(0, 20, hits); check("duty0_inv_hits", hits, 20);
        count_high(1, 20, hits); check("duty_gt_period_hits", hits, 20);

        // Byte strobes: only byte 1 of PERIOD changes
        axi_write(6'h04, 32'h0000_AB55, 4'b0010, 0);
        axi_read(6'h04, 0, rd); check("strb_period", rd, 32'h0000_AB09);
        axi_write(6'h04, 9, 4'hF, 0);

        // Interrupt set by wrap, cleared by write-1 while stopped
        axi_write(6'h00, 3, 4'hF, 0);
        repeat (12) tick();
        check("irq_set", irq, 1);
        axi_write(6'h00, 2, 4'hF, 0);
        axi_write(6'h0C, 1, 4'hF, 0);
        check("irq_clear", irq, 0);
        axi_read(6'h0C, 0, rd); check("status_clear", rd, 0);

        // Backpressure: B and R held 5 cycles while a new request waits
        AWADDR = 6'h08; WDATA = 32'h5; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 0;
        tick();
        WDATA = 32'hA;
        repeat (5) begin tick(); check("b_hold", BVALID, 1); end
        AWVALID = 0; WVALID = 0; BREADY = 1;
        tick();
        BREADY = 0;
        ARADDR = 6'h08; ARVALID = 1; RREADY = 0;
        tick();
        ARADDR = 6'h3C;
        repeat (5) begin tick(); check("r_hold", RDATA, 5); end
        RREADY = 1;
        tick();
        RREADY = 0;
        tick();
        ARVALID = 0;
        check("unmapped_rd", RDATA, 0);
        check("unmapped_rresp", RRESP, 0);
        RREADY = 1;
        tick();
        RREADY = 0;

        // Reset mid-period and mid-write
        axi_write(6'h10, 4, 4'hF, 0);
        axi_write(6'h00, 7, 4'hF, 0);
        repeat (4) tick();
        AWADDR = 6'h04; WDATA = 32'h33; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
        #3 ARESETN = 0;
        #1 check_reset_outputs("mid");
        model_reset();
        AWVALID = 0; WVALID = 0;
        @(negedge ACLK);
        ARESETN = 1;
        tick();
        for (int i = 0; i < 8; i++) begin
            axi_read(addr_tbl[i], 0, rd);
            check("post_rst_rd", rd, 0);
        end

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            int kind = $urandom_range(0, 9);
            bit [AW-1:0] a = addr_tbl[$urandom_range(0, 9)];
            bit [31:0] d;
            bit [3:0] s = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
            if (a == 6'h00) d = {29'd0, 1'($urandom), 1'($urandom), ($urandom_range(0, 4) != 0)};
            else if ($urandom_range(0, 9) == 0) d = $urandom;
            else d = $urandom_range(0, 20);
            if (kind < 5) axi_write(a, d, s, $urandom_range(0, 3));
            else if (kind < 9) axi_read(a, $urandom_range(0, 3), rd);
            else repeat ($urandom_range(1, 15)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
